// File: rtl/ir_pkg.sv
// Shared types and constants for the IR number-entry path.
package ir_pkg;

    // Entry controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } entry_state_t;

    // Largest decimal digit code the decoder may deliver.
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Minimum binary width able to hold any value of 'digits' decimal digits.
    function automatic int unsigned value_w_min(input int unsigned digits);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Loadable down-counter used as the inter-digit timeout; saturates at zero.
module entry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Load takes precedence over counting; hold at zero once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/ir_number_entry.sv
// Multi-digit decimal entry from IR digit strobes: BCD image, binary value,
// commit on digit limit or timeout, abort on decoder error, valid/ready output.
module ir_number_entry
    import ir_pkg::*;
#(
    parameter int unsigned MAX_DIGITS     = 4,
    parameter int unsigned VALUE_W        = 14,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    localparam int unsigned BCD_W = 4 * MAX_DIGITS,
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               numberPressed,
    input  logic [3:0]         numberPressedData,
    input  logic               err,
    output logic [VALUE_W-1:0] value,
    output logic               valueValid,
    input  logic               valueReady,
    output logic [BCD_W-1:0]   bcd,
    output logic [CNT_W-1:0]   digitCount,
    output logic               entryActive,
    output logic               dropped
);

    // Refuse to build with a value register too narrow for the digit limit.
    if (VALUE_W < value_w_min(MAX_DIGITS)) begin : g_value_w_too_small
        $error("ir_number_entry: VALUE_W too small for MAX_DIGITS");
    end

    entry_state_t       state_q, state_d;
    logic [VALUE_W-1:0] acc_q, acc_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dropped_q, dropped_d;

    logic               tmr_load, tmr_en, tmr_expired;
    logic               press_ok;
    logic [VALUE_W+3:0] acc_wide;
    logic [VALUE_W-1:0] acc_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic               unused_acc_ovf;

    entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Digit codes 10-15 are not presses at all.
    assign press_ok = numberPressed && (numberPressedData <= DIGIT_MAX);

    // acc*10 + d as two shifts, with headroom; overflow bits are discarded.
    assign acc_wide = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                    + (VALUE_W+4)'(numberPressedData);
    assign acc_next       = acc_wide[VALUE_W-1:0];
    assign unused_acc_ovf = ^acc_wide[VALUE_W+3:VALUE_W];
    assign cnt_inc        = cnt_q + 1'b1;

    // Next-state and datapath: err > press > timeout; COMMIT freezes the entry.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        value_d   = value_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        dropped_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if ((state_q == ST_ENTRY) && err) begin
                    state_d   = ST_IDLE;
                    acc_d     = '0;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    dropped_d = press_ok;
                end else if (press_ok) begin
                    acc_d    = acc_next;
                    bcd_d    = (bcd_q << 4) | BCD_W'(numberPressedData);
                    cnt_d    = cnt_inc;
                    tmr_load = 1'b1;
                    if (cnt_inc == CNT_W'(MAX_DIGITS)) begin
                        state_d = ST_COMMIT;
                        value_d = acc_next;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else if (state_q == ST_ENTRY) begin
                    if (tmr_expired) begin
                        state_d = ST_COMMIT;
                        value_d = acc_q;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                dropped_d = press_ok;
                if (valueReady) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                bcd_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and entry registers; reset discards any pending value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            value_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            value_q   <= value_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
        end
    end

    assign value       = value_q;
    assign valueValid  = (state_q == ST_COMMIT);
    assign bcd         = bcd_q;
    assign digitCount  = cnt_q;
    assign entryActive = (state_q == ST_ENTRY);
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_ir_number_entry.sv
// Directed bench for ir_number_entry with a 16-cycle timeout.
module tb_ir_number_entry;

    localparam int unsigned MAX_DIGITS = 4;
    localparam int unsigned VALUE_W    = 14;
    localparam int unsigned TMO        = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        numberPressed = 1'b0;
    logic [3:0]  numberPressedData = 4'd0;
    logic        err = 1'b0;
    logic        valueReady = 1'b0;
    logic [13:0] value;
    logic        valueValid;
    logic [15:0] bcd;
    logic [2:0]  digitCount;
    logic        entryActive;
    logic        dropped;

    int pass_cnt = 0;
    int total    = 0;

    ir_number_entry #(
        .MAX_DIGITS     (MAX_DIGITS),
        .VALUE_W        (VALUE_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .numberPressed     (numberPressed),
        .numberPressedData (numberPressedData),
        .err               (err),
        .value             (value),
        .valueValid        (valueValid),
        .valueReady        (valueReady),
        .bcd               (bcd),
        .digitCount        (digitCount),
        .entryActive       (entryActive),
        .dropped           (dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        np;
        logic [3:0]  d;
        logic        e;
        logic        rdy;
        logic        vv;
        logic [13:0] val;
        logic [15:0] bcd;
        logic [2:0]  cnt;
        logic        act;
        logic        drp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic np, logic [3:0] d, logic e, logic rdy,
                                logic vv, logic [13:0] val, logic [15:0] b,
                                logic [2:0] c, logic act, logic drp);
        vec_t v;
        v.np = np; v.d = d; v.e = e; v.rdy = rdy;
        v.vv = vv; v.val = val; v.bcd = b; v.cnt = c; v.act = act; v.drp = drp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        numberPressed = 1'b1;
        numberPressedData = d;
        step();
        numberPressed = 1'b0;
    endtask

    // Steps until valueValid; n = cycles since the last sample, capped.
    task automatic wait_valid(output int n);
        n = 1;
        while (!valueValid && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic handshake();
        valueReady = 1'b1;
        step();
        valueReady = 1'b0;
    endtask

    int n;
    logic seen_vv;

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_value", 32'(value), 0);
        chk("rst_vv", 32'(valueValid), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_cnt", 32'(digitCount), 0);
        chk("rst_act", 32'(entryActive), 0);
        chk("rst_drop", 32'(dropped), 0);
        rst = 1'b0;
        step();

        // Table: 1,(12 ignored),2,3,4 auto-commit; 10-cycle hold with a dropped 5;
        // handshake; err ignored in IDLE; err+press in ENTRY aborts with drop.
        vecs.push_back(mk(1, 4'd1,  0, 0, 0, 0,    16'h0001, 1, 1, 0));
        vecs.push_back(mk(1, 4'd12, 0, 0, 0, 0,    16'h0001, 1, 1, 0));
        vecs.push_back(mk(1, 4'd2,  0, 0, 0, 0,    16'h0012, 2, 1, 0));
        vecs.push_back(mk(1, 4'd3,  0, 0, 0, 0,    16'h0123, 3, 1, 0));
        vecs.push_back(mk(1, 4'd4,  0, 0, 1, 1234, 16'h1234, 4, 0, 0));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) vecs.push_back(mk(1, 4'd5, 0, 0, 1, 1234, 16'h1234, 4, 0, 1));
            else        vecs.push_back(mk(0, 4'd0, 0, 0, 1, 1234, 16'h1234, 4, 0, 0));
        end
        vecs.push_back(mk(0, 4'd0,  0, 1, 0, 0,    16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 4'd9,  1, 0, 0, 0,    16'h0009, 1, 1, 0));
        vecs.push_back(mk(1, 4'd6,  1, 0, 0, 0,    16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 4'd0,  0, 0, 0, 0,    16'h0000, 0, 0, 0));

        foreach (vecs[i]) begin
            numberPressed = vecs[i].np;
            numberPressedData = vecs[i].d;
            err = vecs[i].e;
            valueReady = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_vv", i), 32'(valueValid), 32'(vecs[i].vv));
            if (vecs[i].vv) chk($sformatf("v%0d_value", i), 32'(value), 32'(vecs[i].val));
            chk($sformatf("v%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
            chk($sformatf("v%0d_cnt", i), 32'(digitCount), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_act", i), 32'(entryActive), 32'(vecs[i].act));
            chk($sformatf("v%0d_drop", i), 32'(dropped), 32'(vecs[i].drp));
        end
        numberPressed = 1'b0;
        err = 1'b0;
        valueReady = 1'b0;

        // 4,2 then timeout: valid 17 cycles after the second strobe
        press(4'd4);
        press(4'd2);
        wait_valid(n);
        chk("tmo42_latency", 32'(n), TMO + 1);
        chk("tmo42_value", 32'(value), 42);
        chk("tmo42_bcd", 32'(bcd), 32'h0042);
        chk("tmo42_cnt", 32'(digitCount), 2);
        handshake();
        chk("tmo42_vv_clr", 32'(valueValid), 0);

        // 7 then err for 3 cycles: abort, never valid
        press(4'd7);
        chk("err_act_pre", 32'(entryActive), 1);
        err = 1'b1;
        step(); step(); step();
        err = 1'b0;
        chk("err_act", 32'(entryActive), 0);
        chk("err_bcd", 32'(bcd), 0);
        chk("err_cnt", 32'(digitCount), 0);
        seen_vv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valueValid) seen_vv = 1'b1;
        end
        chk("err_no_vv", 32'(seen_vv), 0);

        // 0,0,7 then timeout: leading zeros count as digits
        press(4'd0);
        press(4'd0);
        press(4'd7);
        wait_valid(n);
        chk("z7_vv", 32'(valueValid), 1);
        chk("z7_value", 32'(value), 7);
        chk("z7_cnt", 32'(digitCount), 3);
        chk("z7_bcd", 32'(bcd), 32'h0007);
        handshake();
        chk("z7_vv_clr", 32'(valueValid), 0);
        chk("z7_idle_act", 32'(entryActive), 0);
        chk("z7_idle_cnt", 32'(digitCount), 0);

        // 3, then 8 on the exact cycle the timer reads 0: press wins
        press(4'd3);
        for (int i = 0; i < TMO - 1; i++) step();
        chk("race_vv_pre", 32'(valueValid), 0);
        press(4'd8);
        chk("race_vv", 32'(valueValid), 0);
        chk("race_cnt", 32'(digitCount), 2);
        chk("race_bcd", 32'(bcd), 32'h0038);
        wait_valid(n);
        chk("race_latency", 32'(n), TMO + 1);
        chk("race_value", 32'(value), 38);
        handshake();

        // 9 then asynchronous reset mid-entry
        press(4'd9);
        chk("arst_act_pre", 32'(entryActive), 1);
        rst = 1'b1;
        #1;
        chk("arst_act", 32'(entryActive), 0);
        chk("arst_bcd", 32'(bcd), 0);
        chk("arst_cnt", 32'(digitCount), 0);
        chk("arst_vv", 32'(valueValid), 0);
        chk("arst_value", 32'(value), 0);
        step();
        rst = 1'b0;
        step();
        press(4'd5);
        chk("arst_fresh_bcd", 32'(bcd), 32'h0005);
        chk("arst_fresh_cnt", 32'(digitCount), 1);
        wait_valid(n);
        chk("arst_fresh_vv", 32'(valueValid), 1);
        chk("arst_fresh_value", 32'(value), 5);
        handshake();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
